// File: rtl/img_writer.sv
// img_writer: captures one frame of RGB888 pixels from a valid/ready stream
// and writes it linearly into a word-addressed memory (address = y*IMG_W + x).
//
// Optional feature macro: IMG_WRITER_CHECKSUM_EN adds a 24-bit running sum
// of the written pixels on the `checksum` port.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   arm                 one-cycle pulse, arms capture of the next frame (IDLE only)
//   s_valid/s_ready     pixel stream handshake; s_data is RGB888, s_sof marks pixel 0
//   mem_busy            memory stall; s_ready drops while it is high
//   mem_we/addr/wdata   registered write port, one cycle after each transfer
//   busy                capture in progress (WAIT_SOF or WRITE)
//   frame_done          one-cycle pulse the cycle after the last write
//   sof_err             sticky: s_sof arrived mid-frame (cleared by an accepted arm)
//   checksum            (macro only) sum of frame pixels mod 2^24

module img_writer #(
    parameter int IMG_W = 200,
    parameter int IMG_H = 240,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arm,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [23:0]   s_data,
    input  logic          s_sof,
    input  logic          mem_busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [23:0]   mem_wdata,
    output logic          busy,
    output logic          frame_done,
    output logic          sof_err
`ifdef IMG_WRITER_CHECKSUM_EN
   ,output logic [23:0]   checksum
`endif
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, WRITE, DONE} state_t;

    state_t          state_q;
    logic [XW-1:0]   x_q, wr_x_d, x_d;
    logic [YW-1:0]   y_q, wr_y_d, y_d;
    logic [AW-1:0]   addr_q, wr_addr_d, addr_d;
    logic            last_d;
    logic            xfer, wr_en;
    logic            mem_we_q, busy_q, frame_done_q, sof_err_q;
    logic [AW-1:0]   mem_addr_q;
    logic [23:0]     mem_wdata_q;

    // Ready follows the memory stall directly so no beat is ever accepted
    // that the write port cannot retire next cycle.
    assign s_ready = ((state_q == WAIT_SOF) || (state_q == WRITE)) && !mem_busy;
    assign xfer    = s_valid && s_ready;
    // In WAIT_SOF only the SOF beat is written; earlier beats are dropped.
    assign wr_en   = xfer && (s_sof || (state_q == WRITE));

    // Position of the pixel being written this cycle and the position after it.
    // An SOF beat always lands at 0, which also implements the mid-frame restart.
    always_comb begin
        wr_x_d    = x_q;
        wr_y_d    = y_q;
        wr_addr_d = addr_q;
        if (s_sof) begin
            wr_x_d    = '0;
            wr_y_d    = '0;
            wr_addr_d = '0;
        end
        last_d = (wr_x_d == X_LAST) && (wr_y_d == Y_LAST);
        x_d    = wr_x_d + 1'b1;
        y_d    = wr_y_d;
        addr_d = wr_addr_d + 1'b1;
        if (wr_x_d == X_LAST) begin
            x_d = '0;
            y_d = wr_y_d + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q   <= WAIT_SOF;
                        busy_q    <= 1'b1;
                        sof_err_q <= 1'b0;
                    end
                end
                WAIT_SOF, WRITE: begin
                    if (wr_en) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_addr_d;
                        mem_wdata_q <= s_data;
                        if (s_sof && (state_q == WRITE))
                            sof_err_q <= 1'b1;
                        if (last_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            x_q     <= '0;
                            y_q     <= '0;
                            addr_q  <= '0;
                        end else begin
                            state_q <= WRITE;
                            x_q     <= x_d;
                            y_q     <= y_d;
                            addr_q  <= addr_d;
                        end
                    end
                end
                DONE: begin
                    // frame_done appears the cycle after the final mem_we.
                    state_q      <= IDLE;
                    frame_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

`ifdef IMG_WRITER_CHECKSUM_EN
    logic [23:0] csum_q;

    // Tracks the same beats as the write port, so after the last write it
    // holds the whole-frame sum and stays put until the next SOF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum_q <= '0;
        else if (wr_en)
            csum_q <= s_sof ? s_data : (csum_q + s_data);
    end

    assign checksum = csum_q;
`endif

endmodule
